// File: rtl/word_combiner.sv
// Packs N_WORDS MSB-aligned variable-length codewords per beat into one bitstream and
// emits the full BLOCK_SIZE-bit blocks a cycle later; leftover bits wait for the next beat.
module word_combiner #(
  parameter int BLOCK_SIZE  = 32,
  parameter int N_WORDS     = 4,
  parameter int MAX_LENGTH  = 48,
  parameter int LENGTH_BITS = $clog2(MAX_LENGTH),
  parameter int MAX_BLOCKS  = (N_WORDS*MAX_LENGTH + 2*BLOCK_SIZE - 2) / BLOCK_SIZE
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic [N_WORDS*MAX_LENGTH-1:0]    in_words,
  input  logic [N_WORDS*LENGTH_BITS-1:0]   in_lengths,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic [MAX_BLOCKS*BLOCK_SIZE-1:0] out_blocks,
  output logic [$clog2(MAX_BLOCKS+1)-1:0]  out_count,
  output logic                             out_valid
);

  localparam int STREAM_W = MAX_BLOCKS*BLOCK_SIZE;
  localparam int TOT_W    = $clog2(STREAM_W+1);
  localparam int RES_W    = $clog2(BLOCK_SIZE);
  localparam int COUNT_W  = $clog2(MAX_BLOCKS+1);

  // residual is kept MSB-aligned in a full block so a flush can emit it unchanged
  logic [BLOCK_SIZE-1:0]  res_data_q, res_data_d;
  logic [RES_W-1:0]       res_len_q, res_len_d;
  logic [STREAM_W-1:0]    out_blocks_q, out_blocks_d;
  logic [COUNT_W-1:0]     out_count_q, out_count_d;
  logic                   out_valid_q, out_valid_d;

  logic [LENGTH_BITS-1:0] len_c  [N_WORDS];
  logic [MAX_LENGTH-1:0]  word_m [N_WORDS];
  logic [STREAM_W-1:0]    stream;
  logic [TOT_W-1:0]       total;
  logic [TOT_W-1:0]       nblk;
  logic [TOT_W-1:0]       rem;
  logic                   flush;
  logic [COUNT_W-1:0]     count;

  // Illegal lengths are clamped so one bad beat cannot overrun the stream buffer.
  always_comb begin
    for (int i = 0; i < N_WORDS; i++) begin
      len_c[i] = (in_lengths[i*LENGTH_BITS +: LENGTH_BITS] > LENGTH_BITS'(MAX_LENGTH))
               ? LENGTH_BITS'(MAX_LENGTH)
               : in_lengths[i*LENGTH_BITS +: LENGTH_BITS];
      word_m[i] = in_words[i*MAX_LENGTH +: MAX_LENGTH]
                & ~({MAX_LENGTH{1'b1}} >> len_c[i]);
    end
  end

  always_comb begin
    stream = '0;
    stream[STREAM_W-1 -: BLOCK_SIZE] = res_data_q;
    total = TOT_W'(res_len_q);
    for (int i = 0; i < N_WORDS; i++) begin
      stream = stream | ({word_m[i], {(STREAM_W-MAX_LENGTH){1'b0}}} >> total);
      total  = total + TOT_W'(len_c[i]);
    end
  end

  always_comb begin
    nblk  = TOT_W'(total / TOT_W'(BLOCK_SIZE));
    rem   = TOT_W'(total % TOT_W'(BLOCK_SIZE));
    // a flushed residual is already zero-padded in the slot right after the full blocks
    flush = in_last && (rem != '0);
    count = COUNT_W'(nblk) + COUNT_W'(flush);
  end

  always_comb begin
    res_data_d   = res_data_q;
    res_len_d    = res_len_q;
    out_blocks_d = '0;
    out_count_d  = '0;
    out_valid_d  = 1'b0;
    if (in_valid) begin
      for (int k = 0; k < MAX_BLOCKS; k++) begin
        if (COUNT_W'(k) < count) begin
          out_blocks_d[k*BLOCK_SIZE +: BLOCK_SIZE] = stream[STREAM_W-1-k*BLOCK_SIZE -: BLOCK_SIZE];
        end
      end
      out_count_d = count;
      out_valid_d = (count != '0);
      if (flush) begin
        res_data_d = '0;
        res_len_d  = '0;
      end else begin
        res_data_d = BLOCK_SIZE'((stream << (int'(nblk) * BLOCK_SIZE)) >> (STREAM_W - BLOCK_SIZE));
        res_len_d  = RES_W'(rem);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      res_data_q   <= '0;
      res_len_q    <= '0;
      out_blocks_q <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      res_data_q   <= res_data_d;
      res_len_q    <= res_len_d;
      out_blocks_q <= out_blocks_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_blocks = out_blocks_q;
  assign out_count  = out_count_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_word_combiner.sv
// Bench for word_combiner: directed beats followed by random beats, checked against a
// bit-queue reference model of the packed stream.
module tb_word_combiner;

  localparam int BS = 32;
  localparam int NW = 4;
  localparam int ML = 48;
  localparam int LB = 6;
  localparam int MB = 7;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              aresetn;
  logic [NW*ML-1:0]  in_words;
  logic [NW*LB-1:0]  in_lengths;
  logic              in_valid;
  logic              in_last;
  logic [MB*BS-1:0]  out_blocks;
  logic [CW-1:0]     out_count;
  logic              out_valid;

  always #5 clk = ~clk;

  word_combiner dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_words   (in_words),
    .in_lengths (in_lengths),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .out_blocks (out_blocks),
    .out_count  (out_count),
    .out_valid  (out_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit               model_q[$];
  logic [MB*BS-1:0] exp_blocks;
  logic [CW-1:0]    exp_count;

  task automatic model_beat(input logic v, input logic last,
                            input logic [NW*ML-1:0] w, input logic [NW*LB-1:0] l);
    logic [BS-1:0] blk;
    exp_blocks = '0;
    exp_count  = '0;
    if (v) begin
      for (int i = 0; i < NW; i++) begin
        for (int b = 0; b < int'(l[i*LB +: LB]); b++) model_q.push_back(w[i*ML + ML-1-b]);
      end
      while (model_q.size() >= BS || (last && model_q.size() > 0)) begin
        blk = '0;
        for (int b = 0; b < BS; b++) begin
          if (model_q.size() > 0) blk[BS-1-b] = model_q.pop_front();
        end
        exp_blocks[int'(exp_count)*BS +: BS] = blk;
        exp_count = exp_count + 1'b1;
      end
    end
  endtask

  task automatic check_out(input string tag);
    n_cmp++;
    assert (out_count === exp_count) else begin
      n_err++;
      $error("FAIL %s out_count: observed %0d expected %0d", tag, out_count, exp_count);
    end
    n_cmp++;
    assert (out_valid === (exp_count != 0)) else begin
      n_err++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, exp_count != 0);
    end
    n_cmp++;
    assert (out_blocks === exp_blocks) else begin
      n_err++;
      $error("FAIL %s out_blocks: observed %h expected %h", tag, out_blocks, exp_blocks);
    end
  endtask

  task automatic check_blk(input string tag, input int k, input logic [BS-1:0] expv);
    n_cmp++;
    assert (out_blocks[k*BS +: BS] === expv) else begin
      n_err++;
      $error("FAIL %s block%0d: observed %h expected %h", tag, k, out_blocks[k*BS +: BS], expv);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CW-1:0] expv);
    n_cmp++;
    assert (out_count === expv) else begin
      n_err++;
      $error("FAIL %s count: observed %0d expected %0d", tag, out_count, expv);
    end
  endtask

  task automatic beat(input logic v, input logic last, input logic [NW*ML-1:0] w,
                      input logic [NW*LB-1:0] l, input string tag);
    in_valid   = v;
    in_last    = last;
    in_words   = w;
    in_lengths = l;
    model_beat(v, last, w, l);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_reset(input int cycles);
    aresetn = 1'b0;
    model_q.delete();
    exp_blocks = '0;
    exp_count  = '0;
    repeat (cycles) @(posedge clk);
    #1;
    check_out("reset");
    aresetn = 1'b1;
  endtask

  localparam logic [NW*ML-1:0] W_T2 = {48'hDDD000000000, 48'hCCCCCC000000,
                                       48'hBBBBBBBBB000, 48'hAAAAAAAAAAAA};
  localparam logic [NW*LB-1:0] L_T2 = {6'd12, 6'd24, 6'd36, 6'd48};
  localparam logic [NW*ML-1:0] W_T4 = {48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF,
                                       48'hFFFFFFFFFFFF, 48'h123456780000};
  localparam logic [NW*LB-1:0] L_T4 = {6'd0, 6'd0, 6'd0, 6'd32};
  localparam logic [NW*ML-1:0] W_ONES = '1;
  localparam logic [NW*LB-1:0] L_R31  = {6'd0, 6'd0, 6'd0, 6'd31};
  localparam logic [NW*LB-1:0] L_MAX  = {6'd48, 6'd48, 6'd48, 6'd48};
  localparam logic [NW*LB-1:0] L_ZERO = '0;

  initial begin
    logic             v, last;
    logic [NW*ML-1:0] w;
    logic [NW*LB-1:0] l;
    int               len;

    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_words   = '0;
    in_lengths = '0;
    do_reset(4);

    beat(1'b1, 1'b0, W_T2, L_T2, "t2");
    check_cnt("t2", 3'd3);
    check_blk("t2", 0, 32'hAAAAAAAA);
    check_blk("t2", 1, 32'hAAAABBBB);
    check_blk("t2", 2, 32'hBBBBBCCC);

    beat(1'b1, 1'b1, W_T2, L_T2, "t3");
    check_cnt("t3", 3'd5);
    check_blk("t3", 0, 32'hCCCDDDAA);
    check_blk("t3", 1, 32'hAAAAAAAA);
    check_blk("t3", 2, 32'hAABBBBBB);
    check_blk("t3", 3, 32'hBBBCCCCC);
    check_blk("t3", 4, 32'hCDDD0000);

    beat(1'b1, 1'b0, W_T4, L_T4, "t4");
    check_cnt("t4", 3'd1);
    check_blk("t4", 0, 32'h12345678);
    beat(1'b1, 1'b1, W_T4, L_T4, "t4_last_exact");
    check_cnt("t4_last_exact", 3'd1);
    beat(1'b1, 1'b1, W_T4, L_ZERO, "zero_len");
    check_cnt("zero_len", 3'd0);

    beat(1'b1, 1'b0, W_ONES, L_R31, "t5_res31");
    beat(1'b1, 1'b0, W_ONES, L_MAX, "t5_worst");
    check_cnt("t5_worst", 3'd6);
    for (int k = 0; k < 6; k++) check_blk("t5_worst", k, 32'hFFFFFFFF);
    check_blk("t5_worst", 6, 32'h00000000);
    beat(1'b0, 1'b1, W_ONES, L_MAX, "idle");
    beat(1'b1, 1'b1, W_T4, L_ZERO, "t5_flush");
    check_cnt("t5_flush", 3'd1);
    check_blk("t5_flush", 0, 32'hFFFFFFFE);

    beat(1'b1, 1'b0, W_T2, L_T2, "t6_pre");
    in_valid = 1'b1;
    do_reset(1);
    beat(1'b1, 1'b0, W_T4, L_T4, "t6");
    check_blk("t6", 0, 32'h12345678);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset(1 + $urandom_range(0, 2));
      v    = ($urandom_range(0, 3) != 0);
      last = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < 6; j++) w[j*32 +: 32] = $urandom();
      for (int i = 0; i < NW; i++) begin
        case ($urandom_range(0, 4))
          0:       len = 0;
          1:       len = ML;
          default: len = $urandom_range(0, ML);
        endcase
        l[i*LB +: LB] = LB'(len);
      end
      beat(v, last, w, l, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
